// File: rtl/t01_mem_pkg.sv
// Shared types for the data-memory responder: access widths, responder states and byte-lane masks.
package t01_mem_pkg;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } data_width_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } resp_state_t;

    typedef enum logic [1:0] {
        KIND_WRITE = 2'd0,
        KIND_READ  = 2'd1,
        KIND_FETCH = 2'd2
    } req_kind_t;

    localparam logic [3:0] SEL_BYTE0   = 4'b0001;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

endpackage

// File: rtl/t01_mem_responder_steer.sv
// Byte-lane steering: lane selects, replicated store data, right-justified load data
// and the misalignment flag for one access width and byte offset.
module t01_lane_steer
    import t01_mem_pkg::*;
(
    input  data_width_t width_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] bus_rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdat_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] byte_shift;

    assign byte_shift = bus_rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        sel_o      = SEL_WORD;
        wdat_o     = wdata_i;
        rdata_o    = bus_rdata_i;
        misalign_o = 1'b0;
        case (width_i)
            BYTE: begin
                sel_o   = SEL_BYTE0 << addr_lo_i;
                wdat_o  = {4{wdata_i[7:0]}};
                rdata_o = {24'b0, byte_shift[7:0]};
            end
            HALFWORD: begin
                sel_o      = addr_lo_i[1] ? SEL_HALF_HI : SEL_HALF_LO;
                wdat_o     = {2{wdata_i[15:0]}};
                rdata_o    = {16'b0, (addr_lo_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0])};
                misalign_o = addr_lo_i[0];
            end
            default: begin
                misalign_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/t01_mem_responder.sv
// Data/fetch request responder bridging the core memory handshake onto a Wishbone-classic port.
//   state     | meaning
//   ST_IDLE   | arbitrate DataWrite > DataRead > InstrRead, latch the request
//   ST_ACCESS | bus cycle open, wait for ack_i or timeout
//   ST_DONE   | one-cycle dhit/ihit (and bus_err) pulse, requests ignored
module t01_mem_responder
    import t01_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        nRST,
    input  logic        DataRead,
    input  logic        DataWrite,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    input  logic [1:0]  datawidth,
    input  logic        InstrRead,
    input  logic [31:0] instr_addr,
    output logic [31:0] data_i,
    output logic [31:0] instr_o,
    output logic        dhit,
    output logic        ihit,
    output logic        bus_err,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    resp_state_t       state_q, state_d;
    req_kind_t         kind_q, kind_d;
    data_width_t       width_q, width_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       instr_q, instr_d;

    data_width_t       st_width;
    logic [1:0]        st_addr_lo;
    logic [3:0]        st_sel;
    logic [31:0]       st_wdat;
    logic [31:0]       st_rdata;
    logic              st_misalign;

    // Live request fields steer lanes while idle; the latched ones steer read data in ACCESS.
    assign st_width   = (state_q == ST_IDLE) ? data_width_t'(datawidth) : width_q;
    assign st_addr_lo = (state_q == ST_IDLE) ? address[1:0] : addr_lo_q;

    t01_lane_steer u_steer (
        .width_i     (st_width),
        .addr_lo_i   (st_addr_lo),
        .wdata_i     (writedata),
        .bus_rdata_i (dat_i),
        .sel_o       (st_sel),
        .wdat_o      (st_wdat),
        .rdata_o     (st_rdata),
        .misalign_o  (st_misalign)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            kind_q    <= KIND_READ;
            width_q   <= WORD;
            addr_lo_q <= 2'b00;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            width_q   <= width_d;
            addr_lo_q <= addr_lo_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            instr_q   <= instr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        width_d   = width_q;
        addr_lo_d = addr_lo_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        data_d    = data_q;
        instr_d   = instr_q;

        case (state_q)
            ST_IDLE: begin
                if (DataWrite || DataRead) begin
                    kind_d    = DataWrite ? KIND_WRITE : KIND_READ;
                    width_d   = st_width;
                    addr_lo_d = address[1:0];
                    if (st_misalign) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                        if (!DataWrite) begin
                            data_d = '0;
                        end
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ACCESS;
                        cyc_d   = 1'b1;
                        we_d    = DataWrite;
                        adr_d   = address & ~32'h3;
                        dat_d   = st_wdat;
                        sel_d   = st_sel;
                        cnt_d   = TC_LOAD;
                    end
                end else if (InstrRead) begin
                    kind_d  = KIND_FETCH;
                    err_d   = 1'b0;
                    state_d = ST_ACCESS;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = instr_addr & ~32'h3;
                    sel_d   = SEL_WORD;
                    cnt_d   = TC_LOAD;
                end
            end
            ST_ACCESS: begin
                if (ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_DONE;
                    if (kind_q == KIND_READ) begin
                        data_d = st_rdata;
                    end else if (kind_q == KIND_FETCH) begin
                        instr_d = dat_i;
                    end
                end else if (cnt_q == '0) begin
                    // Abandoned access: reads of either kind hand back zero.
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    if (kind_q == KIND_READ) begin
                        data_d = '0;
                    end else if (kind_q == KIND_FETCH) begin
                        instr_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign dhit    = (state_q == ST_DONE) && (kind_q != KIND_FETCH);
    assign ihit    = (state_q == ST_DONE) && (kind_q == KIND_FETCH);
    assign bus_err = (state_q == ST_DONE) && err_q;

    assign data_i  = data_q;
    assign instr_o = instr_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;
    assign sel_o   = sel_q;
    assign we_o    = we_q;
    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;

endmodule

// File: doc/t01_mem_responder.md
Name: t01_mem_responder

Overview:
- Responder end of the core's data-memory request protocol (DataRead/DataWrite/address/writedata/datawidth in; dhit/data_i out); also services instruction fetches (ihit).
- Arbitrates data and fetch requests onto one Wishbone-classic manager port toward SRAM/peripherals.
- Steers byte/halfword lanes, detects misalignment and bus timeout, and returns single-cycle hit pulses with right-justified read data.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait for ack_i before aborting (≥1; counter width $clog2(TIMEOUT_CYCLES+1)).

Ports:
- clk  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- DataRead  in  1  data read request; held high until dhit
- DataWrite  in  1  data write request; may be a single-cycle pulse
- address  in  32  data byte address
- writedata  in  32  store data, right-justified
- datawidth  in  2  data_width: BYTE/HALFWORD/WORD
- InstrRead  in  1  fetch request; held until ihit
- instr_addr  in  32  fetch address, word-aligned
- data_i  out  32  read data to core, right-justified, zero-extended
- instr_o  out  32  fetched instruction
- dhit  out  1  one-cycle data completion pulse
- ihit  out  1  one-cycle fetch completion pulse
- bus_err  out  1  one-cycle pulse with hit on misalign or timeout
- adr_o  out  32  bus word address, {addr[31:2],2'b00}
- dat_o  out  32  bus write data
- sel_o  out  4  byte lane selects
- we_o, cyc_o, stb_o  out  1  Wishbone controls
- dat_i  in  32  bus read data
- ack_i  in  1  bus acknowledge

Behaviour:
- Reset: state IDLE; all outputs 0, including data_i, instr_o, adr_o, dat_o, sel_o. Reset mid-access drops cyc_o/stb_o immediately; no hit is issued.
- States: IDLE, ACCESS, DONE.
- IDLE, arbitration:
  - Priority DataWrite > DataRead > InstrRead.
  - Latch kind, address, width and write data on the request cycle.
  - A DataWrite pulse of one cycle must be captured.
- IDLE, misaligned data request (HALFWORD with addr[0]=1; WORD with addr[1:0]≠0):
  - No bus cycle; go to DONE with bus_err=1.
  - A read also zeroes data_i.
- IDLE, otherwise: go to ACCESS.
- ACCESS:
  - cyc_o=stb_o=1, registered; asserted on the first cycle in ACCESS and held until exit.
  - adr_o, we_o, sel_o, dat_o stable throughout.
  - Wait for ack_i. On ack_i: capture read data, go to DONE, deassert cyc_o/stb_o next cycle.
- Write lanes:
  - BYTE: dat_o={4{wd[7:0]}}, sel_o=4'b0001<<addr[1:0].
  - HALFWORD: dat_o={2{wd[15:0]}}, sel_o=addr[1]?4'b1100:4'b0011.
  - WORD: dat_o=wd, sel_o=4'b1111.
- Reads:
  - sel_o uses the same lane rule as writes.
  - data_i = dat_i shifted right by 8*addr[1:0] (BYTE) or 16*addr[1] (HALFWORD), upper bits zero.
  - Sign extension is the core's job.
- Fetches: sel_o=4'b1111, instr_o=dat_i.
- Timeout: counter clears on ACCESS entry. If ack_i is absent for TIMEOUT_CYCLES cycles, drop cyc/stb, go to DONE with bus_err=1; a read returns 0.
- DONE:
  - Pulse exactly one of dhit/ihit for one cycle, then IDLE.
  - Requests are ignored in DONE, so a still-high DataRead is not re-issued.
- Output holding: data_i and instr_o hold their values until the next completion of the same kind.
- Latency: aligned access = 1 (IDLE) + N ack wait cycles (≥1) + 1 (DONE); with zero-wait ack, hit appears on the 3rd cycle after the request.
- Simultaneous data and fetch requests: data is served first; InstrRead stays pending and is served on the next IDLE.

Decomposition:
- Package t01_mem_pkg holds:
  - typedef data_width {BYTE, HALFWORD, WORD}, shared with the core-side data memory block.
  - responder state enum.
  - SEL_* lane constants.
- Sub-module t01_lane_steer (combinational): width + addr[1:0] + wdata/dat_i → sel, dat_o, right-justified read data, misalign flag.

Test Plan:
- WORD write addr 0x100, wd 0xDEADBEEF, ack 1 cycle later → adr_o 0x100, sel_o 1111, we_o 1, dat_o 0xDEADBEEF; one dhit pulse; bus_err 0.
- BYTE read addr 0x203, dat_i 0x80112233 → sel_o 1000, data_i 0x00000080, dhit once; DataRead held through DONE triggers no second bus cycle.
- HALFWORD write addr 0x42, wd 0xFFFF1234 → sel_o 1100, dat_o 0x12341234; DataWrite given as a 1-cycle pulse is still served.
- DataRead and InstrRead same cycle → data access first with dhit; fetch from 0x400 follows, ihit with instr_o = dat_i; dhit and ihit never together.
- WORD read addr 0x102 → no cyc_o; dhit + bus_err pulse; data_i 0.
- TIMEOUT_CYCLES=4, ack never asserted → cyc_o high exactly 4 cycles, then dhit + bus_err; nRST low mid-ACCESS → cyc_o 0 at once, no hit.
